// File: rtl/sevseg_scan_mux.sv
// Time-multiplexed seven-segment scanner: one digit per PERIOD-cycle slot,
// frame-latched segment patterns and brightness, PWM on-window inside each slot.
module sevseg_scan_mux #(
    parameter int NDIG             = 4,
    parameter int PERIOD           = 750,
    parameter int ANODE_ACTIVE_LOW = 1,
    parameter int CBITS            = $clog2(PERIOD)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [7*NDIG-1:0]   seg_in,
    input  logic [3:0]          bright,
    output logic [6:0]          seg_out,
    output logic [NDIG-1:0]     an,
    output logic                tick,
    output logic                frame
);

    localparam int IBITS = $clog2(NDIG);
    localparam logic [CBITS-1:0] CNT_LAST = CBITS'(PERIOD - 1);
    localparam logic [IBITS-1:0] IDX_LAST = IBITS'(NDIG - 1);
    localparam logic [19:0]      STEP_W   = 20'(PERIOD / 16);

    logic [CBITS-1:0]  cnt_reg;
    logic [IBITS-1:0]  idx_reg;
    logic [7*NDIG-1:0] shadow_seg_reg;
    logic [3:0]        shadow_bright_reg;
    logic              tick_reg;
    logic              frame_reg;

    logic              slot_end;
    logic              frame_end;
    logic [19:0]       on_limit;
    logic              on_window;
    logic              active;
    logic [NDIG-1:0]   sel;
    logic [6:0]        digit [NDIG];
    logic [6:0]        seg_mux;

    assign slot_end  = en && (cnt_reg == CNT_LAST);
    assign frame_end = slot_end && (idx_reg == IDX_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg           <= '0;
            idx_reg           <= '0;
            shadow_seg_reg    <= '0;
            shadow_bright_reg <= '0;
            tick_reg          <= 1'b0;
            frame_reg         <= 1'b0;
        end else if (slot_end) begin
            cnt_reg   <= '0;
            idx_reg   <= (idx_reg == IDX_LAST) ? '0 : idx_reg + IBITS'(1);
            tick_reg  <= 1'b1;
            frame_reg <= frame_end;
            // New patterns only take effect at a frame boundary so a frame never mixes old and new data
            if (frame_end) begin
                shadow_seg_reg    <= seg_in;
                shadow_bright_reg <= bright;
            end
        end else begin
            tick_reg  <= 1'b0;
            frame_reg <= 1'b0;
            if (en) begin
                cnt_reg <= cnt_reg + CBITS'(1);
            end
        end
    end

    assign on_limit  = 20'(shadow_bright_reg) * STEP_W;
    assign on_window = (shadow_bright_reg == 4'hF) || (20'(cnt_reg) < on_limit);
    assign active    = on_window && en && !rst;

    generate
        for (genvar gi = 0; gi < NDIG; gi++) begin : g_digit
            assign digit[gi] = shadow_seg_reg[7*gi +: 7];
            assign sel[gi]   = active && (idx_reg == IBITS'(gi));
        end
    endgenerate

    // At most one sel bit is set, so an AND-OR mux picks the active digit
    always_comb begin
        seg_mux = 7'b0;
        for (int i = 0; i < NDIG; i++) begin
            if (sel[i]) begin
                seg_mux = seg_mux | digit[i];
            end
        end
    end

    assign seg_out = seg_mux;
    assign an      = (ANODE_ACTIVE_LOW != 0) ? ~sel : sel;
    assign tick    = tick_reg;
    assign frame   = frame_reg;

endmodule

// File: tb/tb_sevseg_scan_mux.sv
// Directed bench for sevseg_scan_mux: two instances (PERIOD 8 and 32) share stimulus,
// a per-cycle reference model feeds a scoreboard, plus explicit timing checks.
module tb_sevseg_scan_mux;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic [27:0] seg_in = '0;
    logic [3:0]  bright = 4'hF;

    logic [6:0]  seg_a, seg_b;
    logic [3:0]  an_a, an_b;
    logic        tick_a, tick_b, frame_a, frame_b;

    always #5 clk = ~clk;

    sevseg_scan_mux #(.NDIG(4), .PERIOD(8), .ANODE_ACTIVE_LOW(1)) dut8 (
        .clk(clk), .rst(rst), .en(en), .seg_in(seg_in), .bright(bright),
        .seg_out(seg_a), .an(an_a), .tick(tick_a), .frame(frame_a)
    );

    sevseg_scan_mux #(.NDIG(4), .PERIOD(32), .ANODE_ACTIVE_LOW(1)) dut32 (
        .clk(clk), .rst(rst), .en(en), .seg_in(seg_in), .bright(bright),
        .seg_out(seg_b), .an(an_b), .tick(tick_b), .frame(frame_b)
    );

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       tick;
        logic       frame;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   n = 0;

    int         m_cnt [2] = '{0, 0};
    int         m_idx [2] = '{0, 0};
    logic [27:0] m_sseg [2] = '{28'h0, 28'h0};
    logic [3:0] m_sb [2] = '{4'h0, 4'h0};
    logic       m_tick [2] = '{1'b0, 1'b0};
    logic       m_frame [2] = '{1'b0, 1'b0};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance the reference model by one edge, queue its predictions, then compare both DUTs.
    task automatic step();
        exp_t e;
        exp_t ea;
        exp_t eb;
        for (int i = 0; i < 2; i++) begin
            int p;
            logic on;
            p = (i == 0) ? 8 : 32;
            if (rst) begin
                m_cnt[i] = 0; m_idx[i] = 0; m_sseg[i] = '0; m_sb[i] = '0;
                m_tick[i] = 1'b0; m_frame[i] = 1'b0;
            end else if (en) begin
                m_tick[i]  = (m_cnt[i] == p - 1);
                m_frame[i] = m_tick[i] && (m_idx[i] == 3);
                if (m_frame[i]) begin
                    m_sseg[i] = seg_in;
                    m_sb[i]   = bright;
                end
                if (m_tick[i]) begin
                    m_cnt[i] = 0;
                    m_idx[i] = (m_idx[i] + 1) % 4;
                end else begin
                    m_cnt[i] = m_cnt[i] + 1;
                end
            end else begin
                m_tick[i]  = 1'b0;
                m_frame[i] = 1'b0;
            end
            on = (m_sb[i] == 4'hF) || (m_cnt[i] < int'(m_sb[i]) * (p / 16));
            e.tick  = m_tick[i];
            e.frame = m_frame[i];
            if (!rst && en && on) begin
                e.an  = ~(4'b0001 << m_idx[i]);
                e.seg = m_sseg[i][m_idx[i]*7 +: 7];
            end else begin
                e.an  = 4'hF;
                e.seg = 7'h0;
            end
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        n++;
        ea = sb.pop_front();
        eb = sb.pop_front();
        chk("p8.an", an_a, ea.an);
        chk("p8.seg", seg_a, ea.seg);
        chk("p8.tick", tick_a, ea.tick);
        chk("p8.frame", frame_a, ea.frame);
        chk("p32.an", an_b, eb.an);
        chk("p32.seg", seg_b, eb.seg);
        chk("p32.tick", tick_b, eb.tick);
        chk("p32.frame", frame_b, eb.frame);
    endtask

    task automatic run_to(input int target);
        while (n < target) step();
    endtask

    initial begin
        int tick_times[$];
        int frame_times[$];
        logic [3:0] an_seq [4];
        int on_cnt;
        int hold_cnt;
        int hold_idx;
        int wait_cnt;
        bit found;

        // Reset for three cycles
        for (int i = 0; i < 3; i++) step();
        chk("rst.an", an_a, 4'hF);
        chk("rst.seg", seg_a, 7'h0);
        chk("rst.tick", tick_a, 1'b0);
        chk("rst.frame", frame_a, 1'b0);

        // Free run at full brightness; first frame stays blank until the shadow loads
        seg_in = {7'h66, 7'h4F, 7'h5B, 7'h06};
        rst = 1'b0;
        n = 0;
        while (n < 80) begin
            step();
            if (tick_a) tick_times.push_back(n);
            if (frame_a) frame_times.push_back(n);
            if (n == 31) chk("blank.first_frame", an_a, 4'hF);
            if (n == 32) an_seq[0] = an_a;
            if (n == 40) an_seq[1] = an_a;
            if (n == 48) an_seq[2] = an_a;
            if (n == 56) an_seq[3] = an_a;
        end
        chk("tick.first", (tick_times.size() > 0) ? tick_times[0] : -1, 8);
        chk("tick.count", tick_times.size(), 10);
        for (int i = 1; i < tick_times.size(); i++)
            chk("tick.gap", tick_times[i] - tick_times[i-1], 8);
        chk("frame.first", (frame_times.size() > 0) ? frame_times[0] : -1, 32);
        chk("frame.second", (frame_times.size() > 1) ? frame_times[1] : -1, 64);
        chk("an.slot0", an_seq[0], 4'b1110);
        chk("an.slot1", an_seq[1], 4'b1101);
        chk("an.slot2", an_seq[2], 4'b1011);
        chk("an.slot3", an_seq[3], 4'b0111);

        // Frame latch: mid-frame change of digit 0 waits for the next frame
        seg_in = 28'h0FFFFFF;
        run_to(96);
        chk("latch.old_d0", seg_a, 7'h7F);
        run_to(106);
        seg_in[6:0] = 7'h3F;
        run_to(128);
        chk("latch.new_d0", seg_a, 7'h3F);
        chk("latch.new_an", an_a, 4'b1110);

        // Brightness on the PERIOD=32 instance
        bright = 4'd4;
        run_to(256);
        on_cnt = 0;
        for (int i = 0; i < 32; i++) begin
            if (an_b !== 4'hF) on_cnt++;
            step();
        end
        chk("bright4.on_cycles", on_cnt, 8);
        bright = 4'd0;
        run_to(384);
        on_cnt = 0;
        for (int i = 0; i < 128; i++) begin
            if (an_b !== 4'hF) on_cnt++;
            step();
        end
        chk("bright0.on_cycles", on_cnt, 0);

        // Enable pause mid-slot on the PERIOD=8 instance
        bright = 4'hF;
        run_to(547);
        hold_cnt = int'(dut8.cnt_reg);
        hold_idx = int'(dut8.idx_reg);
        chk("en.cnt_before", hold_cnt, 3);
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("en.cnt_hold", dut8.cnt_reg, hold_cnt);
            chk("en.idx_hold", dut8.idx_reg, hold_idx);
            chk("en.an_blank", an_a, 4'hF);
            chk("en.seg_blank", seg_a, 7'h0);
        end
        en = 1'b1;
        wait_cnt = 0;
        found = 1'b0;
        while (!found && wait_cnt < 16) begin
            step();
            wait_cnt++;
            if (tick_a) found = 1'b1;
        end
        chk("en.resume_tick", found ? wait_cnt : -1, 5);

        // Reset mid-frame at idx 2, cnt 5
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            if (dut8.idx_reg == 2'd2 && dut8.cnt_reg == 3'd5) found = 1'b1;
            else step();
        end
        chk("midrst.reached", found, 1'b1);
        rst = 1'b1;
        step();
        chk("midrst.idx", dut8.idx_reg, 0);
        chk("midrst.cnt", dut8.cnt_reg, 0);
        chk("midrst.shadow", dut8.shadow_seg_reg, 0);
        chk("midrst.tick", tick_a, 1'b0);
        chk("midrst.frame", frame_a, 1'b0);
        chk("midrst.an", an_a, 4'hF);
        step();
        rst = 1'b0;
        for (int i = 0; i < 12; i++) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
